// File: rtl/meta_chooser.sv
// rtl/meta_chooser.sv - tournament chooser selecting GBP or LBP per fetch PC with saturating counters
//
// Ports:
//   clk, reset          clock; asynchronous active-low reset
//   stall               freezes delay line, GHR, table and statistics
//   flush               squashes every in-flight delay-line entry
//   if_pc               PC currently in IF
//   gbp_pred, lbp_pred  component predictions for if_pc
//   is_branch, is_taken the instruction in ID is a conditional branch / its direction
//   take, use_gbp       final prediction for if_pc / prediction sourced from GBP
//   disagree_cnt        trained disagreements, saturating
//   gbp_win_cnt         disagreements won by GBP, saturating
module meta_chooser #(
    parameter int DELAY    = 7,
    parameter int INDEX    = 10,
    parameter int CTR_W    = 2,
    parameter int HIST     = 10,
    parameter int HASH_GHR = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] if_pc,
    input  logic        gbp_pred,
    input  logic        lbp_pred,
    input  logic        is_branch,
    input  logic        is_taken,
    output logic        take,
    output logic        use_gbp,
    output logic [15:0] disagree_cnt,
    output logic [15:0] gbp_win_cnt
);

    localparam int               ENTRIES  = 1 << INDEX;
    // Weakly prefer LBP; evaluates to 0 when CTR_W is 1.
    localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'((1 << (CTR_W - 1)) - 1);
    localparam logic [CTR_W-1:0] CTR_MAX  = '1;
    localparam logic [15:0]      STAT_MAX = 16'hFFFF;

    typedef struct packed {
        logic             valid;
        logic [INDEX-1:0] idx;
        logic             gbp;
        logic             lbp;
    } dl_entry_t;

    logic [CTR_W-1:0] ctr [ENTRIES];
    dl_entry_t        dl  [DELAY];
    logic [HIST-1:0]  ghr;

    logic [INDEX-1:0] pc_idx;
    logic [INDEX-1:0] ghr_ext;
    logic [INDEX-1:0] fetch_idx;
    logic [HIST:0]    ghr_shift;
    dl_entry_t        head;
    logic             ghr_upd;
    logic             train;
    logic             gbp_right;
    logic [CTR_W-1:0] ctr_cur;
    logic [CTR_W-1:0] ctr_new;
    logic             unused_bits;

    // Lookup and prediction are purely combinational; a counter written on
    // an edge is seen by lookup only from the following cycle (no bypass).
    assign pc_idx    = if_pc[INDEX+1:2];
    assign ghr_ext   = INDEX'(ghr);
    assign fetch_idx = (HASH_GHR != 0) ? (pc_idx ^ ghr_ext) : pc_idx;
    assign use_gbp   = ctr[fetch_idx][CTR_W-1];
    assign take      = use_gbp ? gbp_pred : lbp_pred;

    // Entry 0 describes the instruction now in ID. Its idx was frozen at
    // fetch, so training never rehashes with the current GHR.
    assign head      = dl[0];
    assign ghr_upd   = !stall && head.valid && is_branch;
    assign train     = ghr_upd && (head.gbp != head.lbp);
    assign gbp_right = (head.gbp == is_taken);
    assign ctr_cur   = ctr[head.idx];
    assign ghr_shift = {ghr, is_taken};

    assign unused_bits = ^{if_pc[31:INDEX+2], if_pc[1:0], ghr_shift[HIST]};

    always_comb begin
        ctr_new = ctr_cur;
        if (gbp_right) begin
            if (ctr_cur != CTR_MAX) ctr_new = ctr_cur + 1'b1;
        end else begin
            if (ctr_cur != '0) ctr_new = ctr_cur - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++) ctr[i] <= CTR_INIT;
        end else if (train) begin
            ctr[head.idx] <= ctr_new;
        end
    end

    // Flush clears every valid bit, including the entry pushed on the same
    // edge. Training above still consumes the pre-flush head because the
    // branch in ID is the one that caused the flush.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DELAY; i++) dl[i] <= '0;
        end else if (!stall) begin
            for (int i = 0; i < DELAY - 1; i++) begin
                dl[i]       <= dl[i+1];
                dl[i].valid <= dl[i+1].valid && !flush;
            end
            dl[DELAY-1] <= '{valid: !flush, idx: fetch_idx, gbp: gbp_pred, lbp: lbp_pred};
        end else if (flush) begin
            for (int i = 0; i < DELAY; i++) dl[i].valid <= 1'b0;
        end
    end

    // History is speculative-free: it only shifts on resolved branches and
    // is not rolled back by a flush.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ghr <= '0;
        end else if (ghr_upd) begin
            ghr <= ghr_shift[HIST-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            disagree_cnt <= '0;
            gbp_win_cnt  <= '0;
        end else if (train) begin
            if (disagree_cnt != STAT_MAX) disagree_cnt <= disagree_cnt + 16'd1;
            if (gbp_right && (gbp_win_cnt != STAT_MAX)) gbp_win_cnt <= gbp_win_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_meta_chooser.sv
// tb/tb_meta_chooser.sv - directed self-checking bench for meta_chooser
module tb_meta_chooser;

    logic        clk = 1'b0;
    logic        reset, stall, flush, gbp_pred, lbp_pred, is_branch, is_taken;
    logic [31:0] if_pc;
    logic        take, use_gbp;
    logic [15:0] disagree_cnt, gbp_win_cnt;

    logic        h_reset, h_stall, h_flush, h_gbp, h_lbp, h_is_branch, h_is_taken;
    logic [31:0] h_pc;
    logic        h_take, h_use_gbp;
    logic [15:0] h_disagree_cnt, h_gbp_win_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    meta_chooser u_dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .if_pc(if_pc),
        .gbp_pred(gbp_pred), .lbp_pred(lbp_pred), .is_branch(is_branch), .is_taken(is_taken),
        .take(take), .use_gbp(use_gbp), .disagree_cnt(disagree_cnt), .gbp_win_cnt(gbp_win_cnt)
    );

    meta_chooser #(.HASH_GHR(1)) u_hash (
        .clk(clk), .reset(h_reset), .stall(h_stall), .flush(h_flush), .if_pc(h_pc),
        .gbp_pred(h_gbp), .lbp_pred(h_lbp), .is_branch(h_is_branch), .is_taken(h_is_taken),
        .take(h_take), .use_gbp(h_use_gbp), .disagree_cnt(h_disagree_cnt), .gbp_win_cnt(h_gbp_win_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic peek(input string tag, input logic [31:0] pc, input logic exp);
        logic [31:0] save;
        save  = if_pc;
        if_pc = pc;
        #1;
        check(tag, use_gbp, exp);
        if_pc = save;
    endtask

    task automatic hpeek(input string tag, input logic [31:0] pc, input logic exp);
        logic [31:0] save;
        save = h_pc;
        h_pc = pc;
        #1;
        check(tag, h_use_gbp, exp);
        h_pc = save;
    endtask

    initial begin
        reset = 1'b0; stall = 1'b0; flush = 1'b0; if_pc = 32'h100;
        gbp_pred = 1'b1; lbp_pred = 1'b0; is_branch = 1'b1; is_taken = 1'b1;
        h_reset = 1'b0; h_stall = 1'b0; h_flush = 1'b0; h_pc = 32'h0;
        h_gbp = 1'b1; h_lbp = 1'b1; h_is_branch = 1'b1; h_is_taken = 1'b1;

        // Reset state
        #2;
        check("rst_take", take, 0);
        check("rst_use_gbp", use_gbp, 0);
        check("rst_dis", disagree_cnt, 0);
        check("rst_win", gbp_win_cnt, 0);
        lbp_pred = 1'b1;
        #1;
        check("rst_take_follows_lbp", take, 1);
        lbp_pred = 1'b0;
        step(); step();
        reset = 1'b1;

        // Training lag: fetch edge 1 trains at edge 8, then saturates at 3
        repeat (7) step();
        check("lag_pre_use", use_gbp, 0);
        check("lag_pre_dis", disagree_cnt, 0);
        step();
        check("lag_use", use_gbp, 1);
        check("lag_take", take, 1);
        check("lag_dis", disagree_cnt, 1);
        check("lag_win", gbp_win_cnt, 1);
        step();
        check("sat_hi_dis", disagree_cnt, 2);
        check("sat_hi_win", gbp_win_cnt, 2);

        // GBP wrong: 3->2->1->0->0, then back up 0->1->2
        is_taken = 1'b0;
        step(); step();
        check("dec_use", use_gbp, 0);
        check("dec_take", take, 0);
        check("dec_dis", disagree_cnt, 4);
        check("dec_win", gbp_win_cnt, 2);
        step(); step();
        check("sat_lo_use", use_gbp, 0);
        check("sat_lo_dis", disagree_cnt, 6);
        is_taken = 1'b1;
        step();
        check("sat_lo_up1", use_gbp, 0);
        step();
        check("sat_lo_up2", use_gbp, 1);
        check("sat_lo_dis2", disagree_cnt, 8);
        check("sat_lo_win2", gbp_win_cnt, 4);

        // Agreement: drain line without branches, then 20 agreeing branches
        if_pc = 32'h200; lbp_pred = 1'b1; is_branch = 1'b0;
        repeat (7) step();
        is_branch = 1'b1;
        repeat (20) step();
        check("agree_dis", disagree_cnt, 8);
        peek("agree_ctr200", 32'h200, 0);
        peek("agree_ctr100", 32'h100, 1);

        // Stall for 5 cycles moves training of the 0x300 fetch from +7 to +12
        if_pc = 32'h300; lbp_pred = 1'b0;
        step();
        if_pc = 32'h200; lbp_pred = 1'b1;
        repeat (3) step();
        stall = 1'b1;
        repeat (5) step();
        check("stall_dis", disagree_cnt, 8);
        peek("stall_ctr300", 32'h300, 0);
        stall = 1'b0;
        repeat (3) step();
        check("stall_pre_dis", disagree_cnt, 8);
        peek("stall_pre_ctr300", 32'h300, 0);
        step();
        check("stall_post_dis", disagree_cnt, 9);
        check("stall_post_win", gbp_win_cnt, 5);
        peek("stall_post_ctr300", 32'h300, 1);

        // Flush: head (0x400) trains, the three 0x500 fetches and flush-edge tail do not
        if_pc = 32'h400; lbp_pred = 1'b0;
        step();
        if_pc = 32'h200; lbp_pred = 1'b1;
        repeat (3) step();
        if_pc = 32'h500; lbp_pred = 1'b0;
        repeat (3) step();
        if_pc = 32'h600; flush = 1'b1;
        step();
        flush = 1'b0; if_pc = 32'h200; lbp_pred = 1'b1;
        check("flush_head_dis", disagree_cnt, 10);
        check("flush_head_win", gbp_win_cnt, 6);
        peek("flush_ctr400", 32'h400, 1);
        repeat (7) step();
        check("flush_after_dis", disagree_cnt, 10);
        peek("flush_ctr500", 32'h500, 0);
        peek("flush_ctr600", 32'h600, 0);

        // Asynchronous reset mid-cycle
        reset = 1'b0;
        #1;
        check("arst_dis", disagree_cnt, 0);
        check("arst_win", gbp_win_cnt, 0);
        peek("arst_ctr100", 32'h100, 0);
        if_pc = 32'h100; lbp_pred = 1'b0; is_taken = 1'b1;
        step();
        reset = 1'b1;
        repeat (7) step();
        check("arst_pre_dis", disagree_cnt, 0);
        step();
        check("arst_first_dis", disagree_cnt, 1);
        check("arst_first_win", gbp_win_cnt, 1);

        // 70000 more disagreements, statistics saturate at 0xFFFF
        for (int i = 1; i <= 70000; i++) begin
            step();
            if ((i % 10000 == 0) || (i >= 65533 && i <= 65535)) begin
                check("stat_dis", disagree_cnt, (i + 1 > 65535) ? 65535 : i + 1);
                check("stat_win_le_dis", (gbp_win_cnt <= disagree_cnt), 1);
            end
        end
        check("stat_dis_final", disagree_cnt, 16'hFFFF);
        check("stat_win_final", gbp_win_cnt, 16'hFFFF);
        peek("stat_ctr100", 32'h100, 1);

        // Hashed instance: fill GHR with ten 1s, fetch 0x100 at GHR=0x3FF
        h_reset = 1'b1;
        repeat (17) step();
        hpeek("hash_pre", 32'h100, 0);
        h_pc = 32'h100; h_lbp = 1'b0;
        step();
        h_pc = 32'h0; h_lbp = 1'b1; h_is_taken = 1'b0;
        repeat (6) step();
        h_is_taken = 1'b1;
        step();
        // GHR now 0x381; index 0x3BF is reached from PC 0x0F8
        check("hash_dis", h_disagree_cnt, 1);
        hpeek("hash_ctr3bf", 32'h0F8, 1);
        hpeek("hash_pc100_now", 32'h100, 0);
        hpeek("hash_ctr380", 32'h004, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
